// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MUL / SDIV sequencer for the EX stage
// Optional macro MULDIV_EARLY_OUT_EN: MUL leaves RUN once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] acc_nx, x_nx, y_nx;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, diff;
    logic             is_div, neg;
    logic             accept, last_iter, start_dbz;

    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign start_dbz = op && (b == '0);

    // MUL: acc accumulates, x is the shifting multiplicand, y the draining multiplier.
    // SDIV: acc is the partial remainder, x shifts the dividend out and quotient bits in, y is the divisor.
    always_comb begin
        rem_sh = {acc, x[WIDTH-1]};
        diff   = rem_sh - {1'b0, y};
        if (is_div) begin
            y_nx = y;
            if (!diff[WIDTH]) begin
                acc_nx = diff[WIDTH-1:0];
                x_nx   = {x[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh[WIDTH-1:0];
                x_nx   = {x[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = acc + (y[0] ? x : '0);
            x_nx   = x << 1;
            y_nx   = y >> 1;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (!is_div && (y_nx == '0));
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        accept   = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept   = 1'b1;
                    stall    = 1'b1;
                    state_nx = start_dbz ? FIN : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    stall = 1'b1;
                    if (last_iter) begin
                        state_nx = FIN;
                    end
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The instruction may still hold start while reset is asserted.
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            x           <= '0;
            y           <= '0;
            is_div      <= 1'b0;
            neg         <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            is_div <= op;
            neg    <= op && (a[WIDTH-1] ^ b[WIDTH-1]);
            x      <= op ? a_mag : a;
            y      <= op ? b_mag : b;
            if (start_dbz) begin
                result      <= '0;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN && !flush) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nx;
            x   <= x_nx;
            y   <= y_nx;
            if (last_iter) begin
                result      <= is_div ? (neg ? -x_nx : x_nx) : acc_nx;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int W = 64;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0, reset = 1'b0, start = 1'b0, op = 1'b0, flush = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         stall, busy, done, div_by_zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] model_calc(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] sx, sy;
        sx = x;
        sy = y;
        if (!o) return x * y;
        if (y == '0) return '0;
        if (x == MIN && y == '1) return MIN;
        return sx / sy;
    endfunction

    function automatic int model_lat(input logic o, input logic [W-1:0] y);
        int h = 0;
        if (!EO || o) return W;
        for (int i = 0; i < W; i++) if (y[i]) h = i + 1;
        return (h < 1) ? 1 : h;
    endfunction

    // Transaction-level model: RUN cycles remaining, FIN flag, committed result.
    int           m_run_left = 0;
    bit           m_fin = 1'b0;
    bit           m_dbz = 1'b0;
    logic [W-1:0] m_result = '0, m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run_left = 0;
            m_fin      = 1'b0;
            m_dbz      = 1'b0;
            m_result   = '0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_run_left > 0) begin
            if (flush) m_run_left = 0;
            else begin
                m_run_left--;
                if (m_run_left == 0) begin
                    m_fin    = 1'b1;
                    m_result = m_pend;
                    m_dbz    = 1'b0;
                end
            end
        end else if (start && !flush) begin
            m_pend = model_calc(op, a, b);
            if (op && b == '0) begin
                m_fin    = 1'b1;
                m_result = '0;
                m_dbz    = 1'b1;
            end else begin
                m_run_left = model_lat(op, b);
            end
        end
    end

    always @(negedge clk) begin
        bit m_busy, m_stall;
        m_busy  = (m_run_left > 0) || m_fin;
        m_stall = !reset && !flush && ((m_run_left > 0) || (!m_busy && start));
        check("cyc stall", W'(stall), W'(m_stall));
        check("cyc busy", W'(busy), W'(m_busy));
        check("cyc done", W'(done), W'(m_fin));
        check("cyc dbz", W'(div_by_zero), W'(m_dbz));
        check("cyc result", result, m_result);
    end

    task automatic do_op(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp_res, input logic exp_dbz, input int exp_cyc);
        bit seen = 1'b0;
        int cyc  = 0;
        @(posedge clk); #2;
        op = o; a = x; b = y; start = 1'b1;
        #1 check({name, " stall c0"}, W'(stall), W'(1));
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(posedge clk); #2;
            if (done) begin
                seen  = 1'b1;
                cyc   = n;
                start = 1'b0;
            end
        end
        if (!seen) check({name, " done timeout"}, W'(0), W'(1));
        else begin
            check({name, " done cycle"}, W'(cyc), W'(exp_cyc));
            check({name, " result"}, result, exp_res);
            check({name, " dbz"}, W'(div_by_zero), W'(exp_dbz));
            check({name, " stall fin"}, W'(stall), W'(0));
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst stall", W'(stall), W'(0));
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst result", result, '0);
        check("rst dbz", W'(div_by_zero), W'(0));
        reset = 1'b0;

        do_op("mul 7*-3", 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 65);
        @(posedge clk); #2;
        check("mul busy c66", W'(busy), W'(0));

        do_op("sdiv -7/2", 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        do_op("sdiv 7/-2", 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        do_op("sdiv 5/0", 1'b1, 64'd5, 64'd0, 64'd0, 1'b1, 1);
        do_op("sdiv min/-1", 1'b1, MIN, '1, MIN, 1'b0, 65);

        @(posedge clk); #2;
        op = 1'b0; a = 64'd5; b = 64'd6; start = 1'b1;
        repeat (11) @(posedge clk);
        #2 flush = 1'b1;
        #1 check("flush stall", W'(stall), W'(0));
        @(posedge clk); #2;
        check("flush idle", W'(busy), W'(0));
        flush = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("flush no done", W'(done), W'(0));
            check("flush result kept", result, MIN);
        end
        do_op("mul 3*4", 1'b0, 64'd3, 64'd4, 64'd12, 1'b0, EO ? 4 : 65);

        @(posedge clk); #2;
        op = 1'b0; a = 64'd123; b = 64'd456; start = 1'b1;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst stall", W'(stall), W'(0));
        check("arst busy", W'(busy), W'(0));
        check("arst done", W'(done), W'(0));
        check("arst result", result, '0);
        check("arst dbz", W'(div_by_zero), W'(0));
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        do_op("sdiv 100/7", 1'b1, 64'd100, 64'd7, 64'd14, 1'b0, 65);

        do_op("mul 9*5", 1'b0, 64'd9, 64'd5, 64'd45, 1'b0, EO ? 4 : 65);

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
